// File: rtl/sky130_fd_io__xres_filt_nch.sv
// N-channel reset-input conditioner.
// Each channel picks PAD or FILT_IN_H, synchronises it, then runs a small
// filter FSM that accepts a level change only after FILT_CYC consecutive
// equal samples, enforces a minimum assertion time and flags low pulses that
// were too long to be noise but too short to be accepted as a reset.
// XRES_ANY_N is the AND of all channel outputs and feeds the global reset.
//
// FSM states (state_q[i], readable by hierarchical reference):
//   ST_REL  released, output high
//   ST_QLO  qualifying a low level, output still high
//   ST_ASRT asserted, output low, minimum-hold counter running
//   ST_QHI  qualifying a high level, output still low
module sky130_fd_io__xres_filt_nch #(
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 8,
    parameter int MIN_ASSERT  = 16,
    parameter int AMB_LO      = 2,
    parameter int CNT_W       = 8
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           PWR_GOOD_H,
    input  logic [NCH-1:0] ENABLE_H,
    input  logic [NCH-1:0] INP_SEL_H,
    input  logic [NCH-1:0] PAD,
    input  logic [NCH-1:0] FILT_IN_H,
    input  logic           AMBIG_CLR,
    output logic [NCH-1:0] XRES_H_N,
    output logic           XRES_ANY_N,
    output logic [NCH-1:0] AMBIG_H
);

    typedef enum logic [1:0] {
        ST_REL  = 2'd0,
        ST_QLO  = 2'd1,
        ST_ASRT = 2'd2,
        ST_QHI  = 2'd3
    } state_t;

    // Counter thresholds, all compared unsigned at CNT_W bits.
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] MIN_FULL  = CNT_W'(MIN_ASSERT);
    localparam logic [CNT_W-1:0] AMB_TH    = CNT_W'(AMB_LO);

    logic [NCH-1:0]         raw;
    logic [SYNC_STAGES-1:0] sync_q  [NCH];
    logic [NCH-1:0]         s_sync;
    logic [NCH-1:0]         sel_q;
    logic [NCH-1:0]         sel_chg;
    state_t                 state_q [NCH];
    state_t                 state_d [NCH];
    logic [CNT_W-1:0]       cnt_q   [NCH];
    logic [CNT_W-1:0]       cnt_d   [NCH];
    logic [NCH-1:0]         amb_set;
    logic [NCH-1:0]         ambig_q;
    logic [NCH-1:0]         ambig_d;
    logic [NCH-1:0]         xres_n;

    // Source select per channel, then the synchroniser tap and select-change detect.
    always_comb begin
        raw     = '0;
        s_sync  = '0;
        sel_chg = '0;
        for (int i = 0; i < NCH; i++) begin
            raw[i]     = INP_SEL_H[i] ? FILT_IN_H[i] : PAD[i];
            s_sync[i]  = sync_q[i][SYNC_STAGES-1];
            sel_chg[i] = INP_SEL_H[i] ^ sel_q[i];
        end
    end

    // Synchroniser chains and the registered source select.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= '0;
            end
            sel_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            end
            sel_q <= INP_SEL_H;
        end
    end

    // State register: FSM state, counters and the sticky ambiguous flags.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_ASRT;
                cnt_q[i]   <= '0;
            end
            ambig_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            ambig_q <= ambig_d;
        end
    end

    // Next-state logic. Priority: disable, power-bad, source change, filter.
    always_comb begin
        amb_set = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!ENABLE_H[i]) begin
                state_d[i] = ST_REL;
                cnt_d[i]   = '0;
            end else if (!PWR_GOOD_H) begin
                // Hold restarts from zero once power returns.
                state_d[i] = ST_ASRT;
                cnt_d[i]   = '0;
            end else if (sel_chg[i]) begin
                // Abandon any half-qualified transition; asserted channels keep
                // their completed hold (no re-hold after QHI).
                case (state_q[i])
                    ST_QLO: begin
                        state_d[i] = ST_REL;
                        cnt_d[i]   = '0;
                    end
                    ST_QHI: begin
                        state_d[i] = ST_ASRT;
                        cnt_d[i]   = MIN_FULL;
                    end
                    default: ;
                endcase
            end else begin
                case (state_q[i])
                    ST_REL: begin
                        if (!s_sync[i]) begin
                            state_d[i] = ST_QLO;
                            cnt_d[i]   = CNT_ONE;
                        end else begin
                            cnt_d[i] = '0;
                        end
                    end
                    ST_QLO: begin
                        if (!s_sync[i]) begin
                            if (cnt_q[i] >= FILT_LAST) begin
                                state_d[i] = ST_ASRT;
                                cnt_d[i]   = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + CNT_ONE;
                            end
                        end else begin
                            state_d[i] = ST_REL;
                            cnt_d[i]   = '0;
                            amb_set[i] = (cnt_q[i] >= AMB_TH);
                        end
                    end
                    ST_ASRT: begin
                        if (s_sync[i] && (cnt_q[i] >= MIN_LAST)) begin
                            state_d[i] = ST_QHI;
                            cnt_d[i]   = CNT_ONE;
                        end else if (cnt_q[i] < MIN_FULL) begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                    ST_QHI: begin
                        if (s_sync[i]) begin
                            if (cnt_q[i] >= FILT_LAST) begin
                                state_d[i] = ST_REL;
                                cnt_d[i]   = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + CNT_ONE;
                            end
                        end else begin
                            state_d[i] = ST_ASRT;
                            cnt_d[i]   = MIN_FULL;
                        end
                    end
                    default: begin
                        state_d[i] = ST_ASRT;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
        // A set on the same edge as a clear wins.
        ambig_d = (ambig_q & ~{NCH{AMBIG_CLR}}) | amb_set;
    end

    // Outputs: power-bad and RESET force assertion combinationally; a disabled
    // channel is released regardless of its state.
    always_comb begin
        xres_n = '0;
        for (int i = 0; i < NCH; i++) begin
            xres_n[i] = !RESET && PWR_GOOD_H &&
                        (!ENABLE_H[i] || (state_q[i] == ST_REL) || (state_q[i] == ST_QLO));
        end
    end

    assign XRES_H_N   = xres_n;
    assign XRES_ANY_N = &xres_n;
    assign AMBIG_H    = ambig_q;

endmodule

// File: tb/tb_sky130_fd_io__xres_filt_nch.sv
// Directed bench for the reset conditioner at default parameters.
// Vectors are applied on the falling edge, outputs sampled 1 time unit after
// the rising edge. ncyc = 0 means "check combinationally before any edge".
module tb_sky130_fd_io__xres_filt_nch;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwr_good_h;
    logic [1:0] enable_h;
    logic [1:0] inp_sel_h;
    logic [1:0] pad;
    logic [1:0] filt_in_h;
    logic       ambig_clr;
    logic [1:0] xres_h_n;
    logic       xres_any_n;
    logic [1:0] ambig_h;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic       pg;
        logic [1:0] en;
        logic [1:0] sel;
        logic [1:0] pad;
        logic [1:0] filt;
        logic       clr;
        int         ncyc;
        logic [1:0] exp_x;
        logic       exp_any;
        logic [1:0] exp_amb;
    } vec_t;

    vec_t vecs[$];

    sky130_fd_io__xres_filt_nch dut (
        .CLK        (clk),
        .RESET      (rst),
        .PWR_GOOD_H (pwr_good_h),
        .ENABLE_H   (enable_h),
        .INP_SEL_H  (inp_sel_h),
        .PAD        (pad),
        .FILT_IN_H  (filt_in_h),
        .AMBIG_CLR  (ambig_clr),
        .XRES_H_N   (xres_h_n),
        .XRES_ANY_N (xres_any_n),
        .AMBIG_H    (ambig_h)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic r, input logic pg, input logic [1:0] en,
                                input logic [1:0] sel, input logic [1:0] pd,
                                input logic [1:0] ft, input logic clr, input int n,
                                input logic [1:0] ex, input logic ea, input logic [1:0] eb);
        vec_t v;
        v.rst = r; v.pg = pg; v.en = en; v.sel = sel; v.pad = pd; v.filt = ft;
        v.clr = clr; v.ncyc = n; v.exp_x = ex; v.exp_any = ea; v.exp_amb = eb;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic pg, input logic [1:0] en,
                         input logic [1:0] sel, input logic [1:0] pd,
                         input logic [1:0] ft, input logic clr);
        rst = r; pwr_good_h = pg; enable_h = en; inp_sel_h = sel;
        pad = pd; filt_in_h = ft; ambig_clr = clr;
    endtask

    task automatic check_outs(input string name, input logic [1:0] ex,
                              input logic ea, input logic [1:0] eb);
        n_cmp++;
        if (xres_h_n !== ex) begin
            n_bad++;
            $display("FAIL %s XRES_H_N: got %b expected %b", name, xres_h_n, ex);
        end
        n_cmp++;
        if (xres_any_n !== ea) begin
            n_bad++;
            $display("FAIL %s XRES_ANY_N: got %b expected %b", name, xres_any_n, ea);
        end
        n_cmp++;
        if (ambig_h !== eb) begin
            n_bad++;
            $display("FAIL %s AMBIG_H: got %b expected %b", name, ambig_h, eb);
        end
    endtask

    // Advance n rising edges (n > 0) and land just after the last one, or just
    // settle combinationally when n == 0.
    task automatic run(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
        end
        #1;
    endtask

    initial begin
        //   rst pg en     sel    pad    filt   clr  n   exp_x  any  amb
        // Reset values
        add(1, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  2, 2'b00, 0, 2'b00);
        // Power-on hold: released after edge 23
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0, 22, 2'b00, 0, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  1, 2'b11, 1, 2'b00);
        // Channel 0 held low: asserted after edge 10
        add(0, 1, 2'b11, 2'b00, 2'b10, 2'b11, 0,  9, 2'b11, 1, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b10, 2'b11, 0,  1, 2'b10, 0, 2'b00);
        // Short low pulse during assertion: release still 23 edges after assert
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  3, 2'b10, 0, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b10, 2'b11, 0,  2, 2'b10, 0, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0, 17, 2'b10, 0, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  1, 2'b11, 1, 2'b00);
        // 3-sample low pulse: rejected, AMBIG_H[0] set on edge 6
        add(0, 1, 2'b11, 2'b00, 2'b10, 2'b11, 0,  3, 2'b11, 1, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  2, 2'b11, 1, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  1, 2'b11, 1, 2'b01);
        // Clear
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 1,  1, 2'b11, 1, 2'b00);
        // 1-sample glitch: below AMB_LO, flag untouched
        add(0, 1, 2'b11, 2'b00, 2'b10, 2'b11, 0,  1, 2'b11, 1, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  5, 2'b11, 1, 2'b00);
        // 2-sample pulse (AMB_LO boundary) with clear on the setting edge: set wins
        add(0, 1, 2'b11, 2'b00, 2'b10, 2'b11, 0,  2, 2'b11, 1, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  2, 2'b11, 1, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 1,  1, 2'b11, 1, 2'b01);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  2, 2'b11, 1, 2'b01);
        // 7-sample pulse (FILT_CYC-1 boundary): no assertion, flag set on edge 10
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 1,  1, 2'b11, 1, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b10, 2'b11, 0,  7, 2'b11, 1, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  2, 2'b11, 1, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  1, 2'b11, 1, 2'b01);
        // Assert ch0, go to QHI, drop power mid-QHI, restore: release 23 edges later
        add(0, 1, 2'b11, 2'b00, 2'b10, 2'b11, 0, 10, 2'b10, 0, 2'b01);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0, 19, 2'b10, 0, 2'b01);
        add(0, 0, 2'b11, 2'b00, 2'b11, 2'b11, 0,  0, 2'b00, 0, 2'b01);
        add(0, 0, 2'b11, 2'b00, 2'b11, 2'b11, 0,  3, 2'b00, 0, 2'b01);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0, 22, 2'b00, 0, 2'b01);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  1, 2'b11, 1, 2'b01);
        // Enable handling: ch0 disabled stays released, disabling ch1 releases at once
        add(0, 1, 2'b10, 2'b00, 2'b00, 2'b11, 0,  9, 2'b11, 1, 2'b01);
        add(0, 1, 2'b10, 2'b00, 2'b00, 2'b11, 0,  1, 2'b01, 0, 2'b01);
        add(0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 0,  0, 2'b11, 1, 2'b01);
        add(0, 1, 2'b00, 2'b00, 2'b11, 2'b11, 0,  3, 2'b11, 1, 2'b01);
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 0,  5, 2'b11, 1, 2'b01);
        // Source switch on ch1 during QLO: back to REL, no assertion, no flag
        add(0, 1, 2'b11, 2'b00, 2'b11, 2'b11, 1,  1, 2'b11, 1, 2'b00);
        add(0, 1, 2'b11, 2'b00, 2'b01, 2'b11, 0,  4, 2'b11, 1, 2'b00);
        add(0, 1, 2'b11, 2'b10, 2'b01, 2'b11, 0,  4, 2'b11, 1, 2'b00);
        add(0, 1, 2'b11, 2'b10, 2'b01, 2'b11, 0, 12, 2'b11, 1, 2'b00);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].pg, vecs[k].en, vecs[k].sel,
                  vecs[k].pad, vecs[k].filt, vecs[k].clr);
            run(vecs[k].ncyc);
            check_outs($sformatf("vec%0d", k), vecs[k].exp_x, vecs[k].exp_any, vecs[k].exp_amb);
            if (vecs[k].ncyc > 0) @(negedge clk);
        end

        // Reset asserted while ch0 is qualifying a low level: immediate reset values
        drive(0, 1, 2'b11, 2'b10, 2'b10, 2'b11, 0);
        run(2);
        @(negedge clk);
        drive(0, 1, 2'b11, 2'b10, 2'b11, 2'b11, 0);
        run(3);
        check_outs("rst_pre_flag", 2'b11, 1'b1, 2'b01);
        @(negedge clk);
        drive(0, 1, 2'b11, 2'b10, 2'b10, 2'b11, 0);
        run(5);
        check_outs("rst_pre_qlo", 2'b11, 1'b1, 2'b01);
        @(negedge clk);
        drive(1, 1, 2'b11, 2'b10, 2'b10, 2'b11, 0);
        run(0);
        check_outs("rst_immediate", 2'b00, 1'b0, 2'b00);
        run(2);
        check_outs("rst_held", 2'b00, 1'b0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
